alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Registered issue stage directly upstream of the ALU adder. It accepts decoded operand bundles over a valid/ready handshake and selects operand sources (rs1/PC, rs2/immediate). It applies result forwarding from the stage after the adder, then drives `opd1`, `opd2` and `alu_op_select` from registers. A 2-entry skid buffer decouples decode from ALU backpressure at full throughput.

## Interface
- `OPERAND_LENGTH`, 32, width of operands and forwarded data
- `REG_ADDR_WIDTH`, 5, register-file address width
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `in_valid` in 1: input bundle valid
- `in_ready` out 1: stage can accept a bundle
- `in_rs1_data`, `in_rs2_data`, `in_imm`, `in_pc` in OPERAND_LENGTH: operand sources
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr` in REG_ADDR_WIDTH: source and destination register numbers
- `in_opd1_sel` in 1: 0 = rs1, 1 = PC
- `in_opd2_sel` in 1: 0 = rs2, 1 = immediate
- `in_alu_op_select` in 3: ALU operation (000 add, 001 sub)
- `fwd_valid` in 1: forwarded result valid this cycle
- `fwd_rd_addr` in REG_ADDR_WIDTH: destination register of the forwarded result
- `fwd_data` in OPERAND_LENGTH: forwarded result value
- `out_valid` out 1: output bundle valid
- `out_ready` in 1: ALU consumes the bundle
- `opd1`, `opd2` out OPERAND_LENGTH: operands to the adder
- `alu_op_select` out 3: operation to the adder
- `out_rd_addr` out REG_ADDR_WIDTH: destination register travelling with the bundle

## Operation
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- The state machine has three states:
  - EMPTY: no valid entry.
  - ONE: output slot valid.
  - FULL: output slot and skid slot both valid.
- in_ready = (state != FULL). out_valid = (state != EMPTY).
- Transitions:
  - EMPTY: on in_fire, go to ONE.
  - ONE: in_fire & !out_fire goes to FULL (bundle enters the skid slot). !in_fire & out_fire goes to EMPTY. Both reload the output slot and stay in ONE.
  - FULL: out_fire moves the skid slot into the output slot and goes to ONE. in_fire cannot occur in FULL.
- Each slot stores the selected opd1/opd2, rs1/rs2 addresses, a use-rs flag per operand, op select and rd address.
- Forwarding match on an operand: use-rs flag set, fwd_valid = 1, fwd_rd_addr equals the operand's rs address, and that address is nonzero.
- On a match the operand is replaced with fwd_data, in these cases:
  - when a bundle is captured, in the same cycle it arrives;
  - every cycle while the bundle waits in either slot.
- A PC or immediate operand is never forwarded.
- Register x0 is never forwarded.
- Bundles leave in arrival order. No bundle is dropped or duplicated.
- Arithmetic width: no arithmetic is performed here; all values are passed through at OPERAND_LENGTH bits.

## Timing
- Latency: a bundle accepted at edge N is presented with out_valid = 1 after edge N.
- Throughput: one bundle per cycle while out_ready = 1.
- Output registers hold stable while out_valid & !out_ready, except for forwarding updates to waiting operands.
- in_ready is combinational from the state only. It never depends on `in_valid` or `out_ready`.
- Reset values: out_valid 0; opd1, opd2, alu_op_select and out_rd_addr all 0; state EMPTY, so in_ready = 1.
- Reset asserted mid-operation discards all buffered bundles immediately, without waiting for a clock edge.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: forwarding is active as described under Operation.
- `ALU_ISSUE_FWD_EN` undefined: the fwd_* ports remain on the interface but are ignored, and operands pass through unmodified.

## Structure
- Shared package `alu_pkg` holds:
  - ALU_OP_ADD = 3'b000 and ALU_OP_SUB = 3'b001;
  - OPD1_SEL_RS1/PC and OPD2_SEL_RS2/IMM;
  - the state encodings EMPTY/ONE/FULL.
- Sub-module `alu_operand_mux` performs operand source select plus the forwarding compare and replace for one operand. It is combinational and instantiated per operand.

## Test plan
- Basic add, out_ready = 1: rs1 = 1, rs2 = 5, op 000, sels 0 → after one edge, opd1 = 1, opd2 = 5, alu_op_select = 000, out_valid = 1.
- Source select: opd1_sel = 1 with pc = 0x100, opd2_sel = 1 with imm = 4, op 001 → opd1 = 0x100, opd2 = 4, alu_op_select = 001.
- Backpressure: out_ready = 0, push A (6,3), B (6,4), C (6,7) → in_ready = 0 after B, and C is held upstream. Raise out_ready → A, B, C emerge in order on consecutive cycles.
- Forwarding with `ALU_ISSUE_FWD_EN`:
  - rs1_addr = 3 with fwd_valid, fwd_rd_addr = 3, fwd_data = 6 → opd1 = 6.
  - rs1_addr = 0 with fwd_rd_addr = 0 → opd1 keeps rs1 data.
  - Without the macro → opd1 keeps rs1 data in both cases.
- Stalled forwarding: bundle with rs2_addr = 7 held under out_ready = 0; fwd 7 ← 0x55 arrives → opd2 becomes 0x55 before out_fire.
- Reset mid-operation: state FULL, rst pulsed → out_valid = 0 and all outputs 0 immediately, in_ready = 1. The first bundle after reset emerges correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue path: op codes, operand source selects
// and the issue-stage skid buffer occupancy states.
// Ports: none (package only).
package alu_pkg;

  localparam logic [2:0] ALU_OP_ADD = 3'b000;
  localparam logic [2:0] ALU_OP_SUB = 3'b001;

  localparam logic OPD1_SEL_RS1 = 1'b0;
  localparam logic OPD1_SEL_PC  = 1'b1;
  localparam logic OPD2_SEL_RS2 = 1'b0;
  localparam logic OPD2_SEL_IMM = 1'b1;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_operand_mux.sv
// Purpose: selects one operand (register vs. alternate source) and replaces a
//          register operand with a matching forwarded result.
// Latency: combinational. Backpressure: none, pure datapath.
// Ports: sel_alt / rs_data / alt_data / rs_addr pick the operand; fwd_* carry
//        the forwarded result; opd is the chosen value, use_rs marks a
//        register-sourced operand.
// Config: ALU_ISSUE_FWD_EN enables the forwarding replace; without it the
//         fwd_* inputs are ignored.
module alu_operand_mux #(
  parameter int OPERAND_LENGTH = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      sel_alt,
  input  logic [OPERAND_LENGTH-1:0] rs_data,
  input  logic [OPERAND_LENGTH-1:0] alt_data,
  input  logic [REG_ADDR_WIDTH-1:0] rs_addr,
  input  logic                      fwd_valid,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_rd_addr,
  input  logic [OPERAND_LENGTH-1:0] fwd_data,
  output logic [OPERAND_LENGTH-1:0] opd,
  output logic                      use_rs
);

  logic hit;

  assign use_rs = !sel_alt;

`ifdef ALU_ISSUE_FWD_EN
  // x0 is hard-wired zero, so a result "written" to it must never be bypassed.
  assign hit = use_rs && fwd_valid && (fwd_rd_addr == rs_addr) && (rs_addr != '0);
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_valid, fwd_rd_addr, fwd_data, rs_addr};
  assign hit        = 1'b0;
`endif

  assign opd = hit ? fwd_data : (use_rs ? rs_data : alt_data);

endmodule

// File: rtl/alu_issue_stage.sv
// Purpose: registered issue stage in front of the ALU adder with operand
//          select, result forwarding and a 2-entry skid buffer.
// Latency: 1 cycle input to output; full throughput while out_ready is high.
// Backpressure: in_ready drops only when both slots are occupied (state-only).
// Ports: in_* valid/ready bundle from decode; fwd_* result from the stage after
//        the adder; out_valid/out_ready with opd1, opd2, alu_op_select and
//        out_rd_addr to the adder. clk rising edge, rst async active-high.
// Config: ALU_ISSUE_FWD_EN enables forwarding (see alu_operand_mux).
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int OPERAND_LENGTH = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPERAND_LENGTH-1:0] in_rs1_data,
  input  logic [OPERAND_LENGTH-1:0] in_rs2_data,
  input  logic [OPERAND_LENGTH-1:0] in_imm,
  input  logic [OPERAND_LENGTH-1:0] in_pc,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
  input  logic                      in_opd1_sel,
  input  logic                      in_opd2_sel,
  input  logic [2:0]                in_alu_op_select,
  input  logic                      fwd_valid,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_rd_addr,
  input  logic [OPERAND_LENGTH-1:0] fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPERAND_LENGTH-1:0] opd1,
  output logic [OPERAND_LENGTH-1:0] opd2,
  output logic [2:0]                alu_op_select,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_addr
);

  typedef struct packed {
    logic [OPERAND_LENGTH-1:0] opd1;
    logic [OPERAND_LENGTH-1:0] opd2;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic                      use_rs1;
    logic                      use_rs2;
    logic [2:0]                op;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } slot_t;

  state_t state_q, state_d;
  slot_t  out_q, out_d, skid_q, skid_d;
  slot_t  in_slot, out_fwd, skid_fwd;
  logic   in_fire, out_fire;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Incoming bundle: source select plus same-cycle forwarding.
  alu_operand_mux #(.OPERAND_LENGTH(OPERAND_LENGTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_in_opd1 (
    .sel_alt(in_opd1_sel == OPD1_SEL_PC), .rs_data(in_rs1_data), .alt_data(in_pc),
    .rs_addr(in_rs1_addr), .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr),
    .fwd_data(fwd_data), .opd(in_slot.opd1), .use_rs(in_slot.use_rs1));
  alu_operand_mux #(.OPERAND_LENGTH(OPERAND_LENGTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_in_opd2 (
    .sel_alt(in_opd2_sel == OPD2_SEL_IMM), .rs_data(in_rs2_data), .alt_data(in_imm),
    .rs_addr(in_rs2_addr), .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr),
    .fwd_data(fwd_data), .opd(in_slot.opd2), .use_rs(in_slot.use_rs2));

  assign in_slot.rs1_addr = in_rs1_addr;
  assign in_slot.rs2_addr = in_rs2_addr;
  assign in_slot.op       = in_alu_op_select;
  assign in_slot.rd       = in_rd_addr;

  // Waiting bundles: the stored operand is fed back through the same mux so a
  // late-arriving result still replaces a register operand. Both data inputs
  // are the stored value, so a PC/immediate operand just recirculates.
  alu_operand_mux #(.OPERAND_LENGTH(OPERAND_LENGTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_out_opd1 (
    .sel_alt(!out_q.use_rs1), .rs_data(out_q.opd1), .alt_data(out_q.opd1),
    .rs_addr(out_q.rs1_addr), .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr),
    .fwd_data(fwd_data), .opd(out_fwd.opd1), .use_rs(out_fwd.use_rs1));
  alu_operand_mux #(.OPERAND_LENGTH(OPERAND_LENGTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_out_opd2 (
    .sel_alt(!out_q.use_rs2), .rs_data(out_q.opd2), .alt_data(out_q.opd2),
    .rs_addr(out_q.rs2_addr), .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr),
    .fwd_data(fwd_data), .opd(out_fwd.opd2), .use_rs(out_fwd.use_rs2));
  alu_operand_mux #(.OPERAND_LENGTH(OPERAND_LENGTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_skid_opd1 (
    .sel_alt(!skid_q.use_rs1), .rs_data(skid_q.opd1), .alt_data(skid_q.opd1),
    .rs_addr(skid_q.rs1_addr), .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr),
    .fwd_data(fwd_data), .opd(skid_fwd.opd1), .use_rs(skid_fwd.use_rs1));
  alu_operand_mux #(.OPERAND_LENGTH(OPERAND_LENGTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_skid_opd2 (
    .sel_alt(!skid_q.use_rs2), .rs_data(skid_q.opd2), .alt_data(skid_q.opd2),
    .rs_addr(skid_q.rs2_addr), .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr),
    .fwd_data(fwd_data), .opd(skid_fwd.opd2), .use_rs(skid_fwd.use_rs2));

  assign out_fwd.rs1_addr  = out_q.rs1_addr;
  assign out_fwd.rs2_addr  = out_q.rs2_addr;
  assign out_fwd.op        = out_q.op;
  assign out_fwd.rd        = out_q.rd;
  assign skid_fwd.rs1_addr = skid_q.rs1_addr;
  assign skid_fwd.rs2_addr = skid_q.rs2_addr;
  assign skid_fwd.op       = skid_q.op;
  assign skid_fwd.rd       = skid_q.rd;

  always_comb begin
    state_d = state_q;
    out_d   = out_fwd;
    skid_d  = skid_fwd;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          out_d   = in_slot;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && !out_fire) begin
          skid_d  = in_slot;
          state_d = FULL;
        end else if (!in_fire && out_fire) begin
          state_d = EMPTY;
        end else if (in_fire && out_fire) begin
          out_d   = in_slot;
        end
      end
      FULL: begin
        if (out_fire) begin
          out_d   = skid_fwd;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign opd1          = out_q.opd1;
  assign opd2          = out_q.opd2;
  assign alu_op_select = out_q.op;
  assign out_rd_addr   = out_q.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic        in_opd1_sel, in_opd2_sel;
  logic [2:0]  in_alu_op_select;
  logic        fwd_valid;
  logic [4:0]  fwd_rd_addr;
  logic [31:0] fwd_data;
  logic        out_valid, out_ready;
  logic [31:0] opd1, opd2;
  logic [2:0]  alu_op_select;
  logic [4:0]  out_rd_addr;

  int n_vec = 0;
  int n_err = 0;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_pc(in_pc),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_opd1_sel(in_opd1_sel), .in_opd2_sel(in_opd2_sel), .in_alu_op_select(in_alu_op_select),
    .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .opd1(opd1), .opd2(opd2),
    .alu_op_select(alu_op_select), .out_rd_addr(out_rd_addr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an in-order queue of at most two bundles; every edge a
  // valid forwarded result overwrites matching register operands of all queued
  // bundles, including the one that arrives on that edge.
  typedef struct {
    logic [31:0] o1, o2;
    logic [4:0]  a1, a2;
    bit          u1, u2;
    logic [2:0]  op;
    logic [4:0]  rd;
  } ent_t;
  ent_t q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      bit acc, pop;
      acc = in_valid && (q.size() < 2);
      pop = (q.size() > 0) && out_ready;
      if (pop) void'(q.pop_front());
      if (acc) begin
        ent_t e;
        e.u1 = !in_opd1_sel;
        e.u2 = !in_opd2_sel;
        e.o1 = in_opd1_sel ? in_pc : in_rs1_data;
        e.o2 = in_opd2_sel ? in_imm : in_rs2_data;
        e.a1 = in_rs1_addr;
        e.a2 = in_rs2_addr;
        e.op = in_alu_op_select;
        e.rd = in_rd_addr;
        q.push_back(e);
      end
      if (FWD && fwd_valid && fwd_rd_addr != 5'd0) begin
        for (int i = 0; i < q.size(); i++) begin
          ent_t e;
          e = q[i];
          if (e.u1 && e.a1 == fwd_rd_addr) e.o1 = fwd_data;
          if (e.u2 && e.a2 == fwd_rd_addr) e.o2 = fwd_data;
          q[i] = e;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      chk("model out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      if (out_valid && q.size() != 0) begin
        chk("model opd1", opd1, q[0].o1);
        chk("model opd2", opd2, q[0].o2);
        chk("model op", {29'd0, alu_op_select}, {29'd0, q[0].op});
        chk("model rd", {27'd0, out_rd_addr}, {27'd0, q[0].rd});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] a1,
                     input logic [4:0] a2, input logic s1, input logic s2,
                     input logic [2:0] op, input logic [4:0] rd);
    in_valid = 1'b1;
    in_rs1_data = r1; in_rs2_data = r2;
    in_rs1_addr = a1; in_rs2_addr = a2;
    in_opd1_sel = s1; in_opd2_sel = s2;
    in_alu_op_select = op; in_rd_addr = rd;
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, " opd1"}, opd1, 32'd0);
    chk({tag, " opd2"}, opd2, 32'd0);
    chk({tag, " op"}, {29'd0, alu_op_select}, 32'd0);
    chk({tag, " rd"}, {27'd0, out_rd_addr}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1;
    in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_pc = '0;
    in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0;
    in_opd1_sel = 1'b0; in_opd2_sel = 1'b0; in_alu_op_select = 3'b000;
    fwd_valid = 1'b0; fwd_rd_addr = '0; fwd_data = '0;
    #3;
    chk_zero_outs("reset");
    #9 rst = 1'b0;

    // Basic add.
    step();
    put(32'd1, 32'd5, 5'd1, 5'd2, 1'b0, 1'b0, 3'b000, 5'd9);
    step();
    in_valid = 1'b0;
    chk("add out_valid", {31'd0, out_valid}, 32'd1);
    chk("add opd1", opd1, 32'd1);
    chk("add opd2", opd2, 32'd5);
    chk("add op", {29'd0, alu_op_select}, 32'd0);
    chk("add rd", {27'd0, out_rd_addr}, 32'd9);
    step();

    // Source select PC / immediate.
    put(32'hdead, 32'hbeef, 5'd1, 5'd2, 1'b1, 1'b1, 3'b001, 5'd3);
    in_pc = 32'h100; in_imm = 32'd4;
    step();
    in_valid = 1'b0;
    chk("sel opd1", opd1, 32'h100);
    chk("sel opd2", opd2, 32'd4);
    chk("sel op", {29'd0, alu_op_select}, 32'd1);
    step();

    // Backpressure: A, B fill the buffer, C is held upstream.
    out_ready = 1'b0;
    put(32'd6, 32'd3, 5'd1, 5'd2, 1'b0, 1'b0, 3'b000, 5'd10);
    step();
    chk("bp after A in_ready", {31'd0, in_ready}, 32'd1);
    put(32'd6, 32'd4, 5'd1, 5'd2, 1'b0, 1'b0, 3'b000, 5'd11);
    step();
    chk("bp after B in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp head A", opd2, 32'd3);
    put(32'd6, 32'd7, 5'd1, 5'd2, 1'b0, 1'b0, 3'b000, 5'd12);
    step();
    step();
    chk("bp hold A", opd2, 32'd3);
    chk("bp hold rd", {27'd0, out_rd_addr}, 32'd10);
    out_ready = 1'b1;
    step();
    chk("bp B next", opd2, 32'd4);
    step();
    in_valid = 1'b0;
    chk("bp C next", opd2, 32'd7);
    step();
    chk("bp drained", {31'd0, out_valid}, 32'd0);

    // Forwarding at capture.
    put(32'd9, 32'd2, 5'd3, 5'd2, 1'b0, 1'b0, 3'b000, 5'd4);
    fwd_valid = 1'b1; fwd_rd_addr = 5'd3; fwd_data = 32'd6;
    step();
    chk("fwd rs1 match", opd1, FWD ? 32'd6 : 32'd9);
    put(32'd9, 32'd2, 5'd0, 5'd2, 1'b0, 1'b0, 3'b000, 5'd4);
    fwd_rd_addr = 5'd0;
    step();
    chk("fwd x0 ignored", opd1, 32'd9);
    put(32'd9, 32'd2, 5'd3, 5'd2, 1'b1, 1'b0, 3'b000, 5'd4);
    in_pc = 32'h200; fwd_rd_addr = 5'd3;
    step();
    in_valid = 1'b0; fwd_valid = 1'b0;
    chk("fwd pc ignored", opd1, 32'h200);
    step();

    // Forwarding while stalled in the output slot.
    out_ready = 1'b0;
    put(32'd1, 32'h11, 5'd1, 5'd7, 1'b0, 1'b0, 3'b000, 5'd5);
    step();
    in_valid = 1'b0;
    chk("stall pre opd2", opd2, 32'h11);
    fwd_valid = 1'b1; fwd_rd_addr = 5'd7; fwd_data = 32'h55;
    step();
    fwd_valid = 1'b0;
    chk("stall fwd opd2", opd2, FWD ? 32'h55 : 32'h11);
    out_ready = 1'b1;
    step();

    // Forwarding into the skid slot.
    out_ready = 1'b0;
    put(32'd1, 32'd0, 5'd4, 5'd0, 1'b0, 1'b0, 3'b000, 5'd6);
    step();
    put(32'd2, 32'd0, 5'd5, 5'd0, 1'b0, 1'b0, 3'b000, 5'd7);
    step();
    in_valid = 1'b0;
    fwd_valid = 1'b1; fwd_rd_addr = 5'd5; fwd_data = 32'hAA;
    step();
    fwd_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("skid fwd opd1", opd1, FWD ? 32'hAA : 32'd2);
    step();

    // Reset mid-operation with both slots full.
    out_ready = 1'b0;
    put(32'd3, 32'd3, 5'd1, 5'd2, 1'b0, 1'b0, 3'b001, 5'd8);
    step();
    put(32'd4, 32'd4, 5'd1, 5'd2, 1'b0, 1'b0, 3'b001, 5'd8);
    step();
    in_valid = 1'b0;
    chk("pre-reset full", {31'd0, in_ready}, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk_zero_outs("mid reset");
    #2 rst = 1'b0;
    out_ready = 1'b1;
    put(32'd21, 32'd22, 5'd1, 5'd2, 1'b0, 1'b0, 3'b000, 5'd13);
    step();
    in_valid = 1'b0;
    chk("post-reset opd1", opd1, 32'd21);
    chk("post-reset opd2", opd2, 32'd22);
    chk("post-reset rd", {27'd0, out_rd_addr}, 32'd13);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
